byte_coalesce_buffer: RTL

//  Parametrised byte-enable write path: merges partial (byte-masked) writes into full words.

---
 rtl/byte_coalesce_buffer.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/byte_coalesce_buffer.sv
// Merges byte-masked write beats into full words and queues finished words in a small output FIFO.
// Define BYTE_COALESCE_TIMEOUT_EN to auto-flush a partial word after TIMEOUT_CYC idle cycles.
module byte_coalesce_buffer #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DATA_W-1:0]          in_data,
   input  logic [DATA_W/8-1:0]        in_byte_en,
   input  logic                       in_flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [DATA_W-1:0]          out_data,
   output logic [DATA_W/8-1:0]        out_be,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                       merging
);

   localparam int NBYTES = DATA_W / 8;
   localparam int OCC_W  = $clog2(DEPTH + 1);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   if ((DATA_W % 8) != 0 || DATA_W < 16) begin : g_bad_width
      $error("byte_coalesce_buffer: DATA_W must be a multiple of 8 and >= 16");
   end
   if (DEPTH < 2) begin : g_bad_depth
      $error("byte_coalesce_buffer: DEPTH must be >= 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("byte_coalesce_buffer: TIMEOUT_CYC must be >= 1");
   end

   typedef enum logic {IDLE, MERGING} state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   acc_data_q, acc_data_d;
   logic [NBYTES-1:0]   acc_mask_q, acc_mask_d;
   logic [DATA_W-1:0]   mem_data_q [DEPTH];
   logic [NBYTES-1:0]   mem_be_q   [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [OCC_W-1:0]    count_q, count_d;

   logic                accept, push, pop;
   logic [DATA_W-1:0]   merged, push_data;
   logic [NBYTES-1:0]   nmask, push_be;

   assign in_ready  = (count_q < DEPTH_C);
   assign out_valid = (count_q != '0);
   assign out_data  = mem_data_q[rd_ptr_q];
   assign out_be    = mem_be_q[rd_ptr_q];
   assign occupancy = count_q;
   assign merging   = (state_q == MERGING);

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;
   assign nmask  = acc_mask_q | in_byte_en;

   always_comb begin
      merged = acc_data_q;
      for (int i = 0; i < NBYTES; i++) begin
         if (in_byte_en[i]) merged[8*i +: 8] = in_data[8*i +: 8];
      end
   end

`ifdef BYTE_COALESCE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
   logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

   // Next-state: an accepted beat always wins over a timeout push in the same cycle.
   always_comb begin
      acc_data_d = acc_data_q;
      acc_mask_d = acc_mask_q;
      push       = 1'b0;
      push_data  = '0;
      push_be    = '0;
`ifdef BYTE_COALESCE_TIMEOUT_EN
      tmo_d      = tmo_q;
`endif
      if (accept) begin
`ifdef BYTE_COALESCE_TIMEOUT_EN
         tmo_d = '0;
`endif
         if ((&nmask) || (in_flush && (|nmask))) begin
            push       = 1'b1;
            push_data  = merged;
            push_be    = nmask;
            acc_data_d = '0;
            acc_mask_d = '0;
         end else if (|nmask) begin
            acc_data_d = merged;
            acc_mask_d = nmask;
         end
      end
`ifdef BYTE_COALESCE_TIMEOUT_EN
      else if (state_q == MERGING) begin
         if (tmo_q >= TMO_LAST) begin
            if (in_ready) begin
               push       = 1'b1;
               push_data  = acc_data_q;
               push_be    = acc_mask_q;
               acc_data_d = '0;
               acc_mask_d = '0;
               tmo_d      = '0;
            end
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end
`endif
      state_d = (acc_mask_d != '0) ? MERGING : IDLE;
      count_d = count_q + OCC_W'(push) - OCC_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         acc_data_q <= '0;
         acc_mask_q <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
`ifdef BYTE_COALESCE_TIMEOUT_EN
         tmo_q      <= '0;
`endif
         for (int i = 0; i < DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_be_q[i]   <= '0;
         end
      end else begin
         state_q    <= state_d;
         acc_data_q <= acc_data_d;
         acc_mask_q <= acc_mask_d;
         count_q    <= count_d;
`ifdef BYTE_COALESCE_TIMEOUT_EN
         tmo_q      <= tmo_d;
`endif
         if (push) begin
            mem_data_q[wr_ptr_q] <= push_data;
            mem_be_q[wr_ptr_q]   <= push_be;
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
         end
      end
   end

endmodule
